// File: rtl/ftdi_sync_arb.sv
// FTDI synchronous-FIFO bus arbiter: bursts RX words into a small FIFO and
// drains the host TX stream onto the bus, with turnaround cycles around reads.
module ftdi_sync_arb #(
  parameter int DW          = 8,
  parameter int RX_DEPTH    = 4,
  parameter int BURST_MAX   = 64,
  parameter int RX_PRIORITY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          data_oe,
  input  logic          rxf_n,
  input  logic          txe_n,
  output logic          rd_n,
  output logic          oe_n,
  output logic          wr_n,
  input  logic [DW-1:0] tx_tdata,
  input  logic          tx_tvalid,
  output logic          tx_tready,
  output logic [DW-1:0] rx_tdata,
  output logic          rx_tvalid,
  input  logic          rx_tready
);
  // state   | meaning
  // IDLE    | bus released, arbitrating
  // RD_TURN | FTDI drives bus (oe_n low), no read yet
  // RD      | read burst, one word per cycle while data and room
  // RD_END  | FTDI releases bus before anyone else may drive
  // WR      | write burst from the TX stream
  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD_TURN, RD, RD_END, WR} state_t;

  state_t        state, state_nx;
  logic          last_rx, last_rx_nx;
  logic [BW-1:0] burst_cnt, burst_nx;

  logic [DW-1:0] mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, rx_req, tx_req, push, pop, full_after, burst_last;

  assign full       = (count == CW'(RX_DEPTH));
  assign rx_req     = !rxf_n && !full;
  assign tx_req     = !txe_n && tx_tvalid;
  assign rx_tvalid  = (count != '0);
  assign rx_tdata   = mem[rd_ptr];
  assign pop        = rx_tvalid && rx_tready;
  assign push       = (state == RD) && rx_req;
  // Leave RD as soon as this capture fills the FIFO so rd_n never pulses into a full buffer
  assign full_after = push && !pop && (count == CW'(RX_DEPTH - 1));
  assign burst_last = (burst_cnt == BW'(BURST_MAX - 1));
  assign data_o     = tx_tdata;

  always_comb begin
    state_nx   = state;
    last_rx_nx = last_rx;
    burst_nx   = burst_cnt;
    rd_n       = 1'b1;
    oe_n       = 1'b1;
    wr_n       = 1'b1;
    data_oe    = 1'b0;
    tx_tready  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_req && (!tx_req || (RX_PRIORITY != 0) || !last_rx)) begin
          state_nx   = RD_TURN;
          last_rx_nx = 1'b1;
          burst_nx   = '0;
        end else if (tx_req) begin
          state_nx   = WR;
          last_rx_nx = 1'b0;
          burst_nx   = '0;
        end
      end
      RD_TURN: begin
        oe_n     = 1'b0;
        state_nx = RD;
      end
      RD: begin
        oe_n = 1'b0;
        rd_n = !rx_req;
        if (push) burst_nx = burst_cnt + BW'(1);
        if (!push || full_after || burst_last) state_nx = RD_END;
      end
      RD_END: state_nx = IDLE;
      WR: begin
        data_oe   = 1'b1;
        wr_n      = !tx_req;
        tx_tready = tx_req;
        if (tx_req) burst_nx = burst_cnt + BW'(1);
        if (!tx_req || burst_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_rx   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      last_rx   <= last_rx_nx;
      burst_cnt <= burst_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end
endmodule

// File: tb/tb_ftdi_sync_arb.sv
// Directed bench for ftdi_sync_arb: a default instance plus an alternating,
// short-burst instance sharing the same stimulus.
module tb_ftdi_sync_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i, tx_tdata;
  logic       rxf_n, txe_n, tx_tvalid, rx_tready;
  logic [7:0] data_o, rx_tdata, b_data_o, b_rx_tdata;
  logic       data_oe, rd_n, oe_n, wr_n, tx_tready, rx_tvalid;
  logic       b_data_oe, b_rd_n, b_oe_n, b_wr_n, b_tx_tready, b_rx_tvalid;
  int         n_pass = 0;
  int         n_total = 0;

  ftdi_sync_arb dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
    .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .oe_n(oe_n), .wr_n(wr_n),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready));

  ftdi_sync_arb #(.BURST_MAX(4), .RX_PRIORITY(0)) dut_alt (
    .clk(clk), .rst(rst), .data_i(data_i), .data_o(b_data_o), .data_oe(b_data_oe),
    .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(b_rd_n), .oe_n(b_oe_n), .wr_n(b_wr_n),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(b_tx_tready),
    .rx_tdata(b_rx_tdata), .rx_tvalid(b_rx_tvalid), .rx_tready(rx_tready));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rxf_n = 1'b1; txe_n = 1'b1; tx_tvalid = 1'b0; rx_tready = 1'b0;
    data_i = 8'h00; tx_tdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxf_n = 1'b0; txe_n = 1'b0; tx_tvalid = 1'b1; rx_tready = 1'b1;
    data_i = 8'h00; tx_tdata = 8'h00;
    #1;
    n_total++;
    if ({rd_n, oe_n, wr_n, data_oe, tx_tready, rx_tvalid} !== 6'b111000)
      $display("FAIL reset_outputs: got %b want 111000", {rd_n, oe_n, wr_n, data_oe, tx_tready, rx_tvalid});
    else n_pass++;
    n_total++;
    if ({b_rd_n, b_oe_n, b_wr_n, b_data_oe, b_tx_tready, b_rx_tvalid} !== 6'b111000)
      $display("FAIL reset_outputs_alt: got %b want 111000", {b_rd_n, b_oe_n, b_wr_n, b_data_oe, b_tx_tready, b_rx_tvalid});
    else n_pass++;
  endtask

  task automatic test_rx_burst();
    logic       rxf [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic [7:0] din [8] = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'h00, 8'h00};
    logic       e_rd [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic       e_oe [8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    logic       e_vld [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic [7:0] e_dat [8] = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rxf_n = rxf[k]; data_i = din[k]; rx_tready = 1'b1;
      #1;
      n_total++;
      if ({rd_n, oe_n, rx_tvalid} !== {e_rd[k], e_oe[k], e_vld[k]})
        $display("FAIL rx_burst_ctrl[%0d]: rd_n,oe_n,vld got %b want %b", k, {rd_n, oe_n, rx_tvalid}, {e_rd[k], e_oe[k], e_vld[k]});
      else n_pass++;
      if (e_vld[k]) begin
        n_total++;
        if (rx_tdata !== e_dat[k]) $display("FAIL rx_burst_data[%0d]: got %h want %h", k, rx_tdata, e_dat[k]);
        else n_pass++;
      end
      n_total++;
      if (data_oe && !oe_n) $display("FAIL bus_contention[rx %0d]: data_oe=1 with oe_n=0", k);
      else n_pass++;
    end
  endtask

  task automatic test_rx_full();
    logic       rxf [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [7:0] din [14] = '{8'h10, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h15, 8'h15};
    logic       rdy [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic       e_rd [14] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1};
    logic       e_oe [14] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    logic       e_vld [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] e_dat [14] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    do_reset();
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      rxf_n = rxf[k]; data_i = din[k]; rx_tready = rdy[k];
      #1;
      n_total++;
      if ({rd_n, oe_n, rx_tvalid} !== {e_rd[k], e_oe[k], e_vld[k]})
        $display("FAIL rx_full_ctrl[%0d]: rd_n,oe_n,vld got %b want %b", k, {rd_n, oe_n, rx_tvalid}, {e_rd[k], e_oe[k], e_vld[k]});
      else n_pass++;
      if (e_vld[k]) begin
        n_total++;
        if (rx_tdata !== e_dat[k]) $display("FAIL rx_full_data[%0d]: got %h want %h", k, rx_tdata, e_dat[k]);
        else n_pass++;
      end
      n_total++;
      if (data_oe && !oe_n) $display("FAIL bus_contention[full %0d]: data_oe=1 with oe_n=0", k);
      else n_pass++;
    end
  endtask

  task automatic test_tx_burst();
    logic [7:0] tx_cnt = 8'd0;
    logic       e_w;
    do_reset();
    for (int k = 0; k < 67; k++) begin
      @(posedge clk); #1;
      txe_n = 1'b0; tx_tvalid = 1'b1; tx_tdata = tx_cnt;
      #1;
      e_w = (k == 0 || k == 65);
      n_total++;
      if ({wr_n, tx_tready, data_oe, oe_n} !== {e_w, !e_w, !e_w, 1'b1})
        $display("FAIL tx_burst_ctrl[%0d]: wr_n,rdy,oe,oe_n got %b want %b", k, {wr_n, tx_tready, data_oe, oe_n}, {e_w, !e_w, !e_w, 1'b1});
      else n_pass++;
      if (!e_w) begin
        n_total++;
        if (data_o !== tx_cnt) $display("FAIL tx_burst_data[%0d]: got %0d want %0d", k, data_o, tx_cnt);
        else n_pass++;
        tx_cnt++;
      end
    end
    n_total++;
    if (data_o !== 8'd64) $display("FAIL tx_next_grant: got %0d want 64", data_o);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_alternate();
    int   seg_t [8];
    int   seg_l [8];
    int   nseg = 0;
    int   prev = 0;
    int   t;
    int   main_wr = 0;
    int   e_t [4] = '{1, 2, 1, 2};
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      rxf_n = 1'b0; txe_n = 1'b0; tx_tvalid = 1'b1; rx_tready = 1'b1;
      data_i = 8'h5A; tx_tdata = 8'h3C;
      #1;
      t = !b_rd_n ? 1 : (!b_wr_n ? 2 : 0);
      if (t != 0) begin
        if (t == prev) seg_l[nseg-1]++;
        else if (nseg < 8) begin seg_t[nseg] = t; seg_l[nseg] = 1; nseg++; end
      end
      prev = t;
      if (!wr_n) main_wr++;
      if (!b_wr_n) begin
        n_total++;
        if (b_data_o !== 8'h3C) $display("FAIL alt_tx_data[%0d]: got %h want 3c", k, b_data_o);
        else n_pass++;
      end
      if (b_rx_tvalid) begin
        n_total++;
        if (b_rx_tdata !== 8'h5A) $display("FAIL alt_rx_data[%0d]: got %h want 5a", k, b_rx_tdata);
        else n_pass++;
      end
      n_total++;
      if ((b_data_oe && !b_oe_n) || (data_oe && !oe_n)) $display("FAIL bus_contention[alt %0d]: data_oe=1 with oe_n=0", k);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= nseg || seg_t[i] != e_t[i] || seg_l[i] != 4)
        $display("FAIL alt_grant[%0d]: got type %0d len %0d want type %0d len 4", i,
                 (i < nseg) ? seg_t[i] : 0, (i < nseg) ? seg_l[i] : 0, e_t[i]);
      else n_pass++;
    end
    n_total++;
    if (main_wr != 0) $display("FAIL rx_priority_starve: got %0d write cycles want 0", main_wr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_rd();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      rxf_n = 1'b0; data_i = (k < 3) ? 8'h55 : 8'h66;
    end
    @(posedge clk); #1;
    n_total++;
    if ({rd_n, oe_n, rx_tvalid} !== 3'b001) $display("FAIL mid_rd_pre: rd_n,oe_n,vld got %b want 001", {rd_n, oe_n, rx_tvalid});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({rd_n, oe_n, rx_tvalid, wr_n, data_oe} !== 5'b11010)
      $display("FAIL mid_rd_reset: rd_n,oe_n,vld,wr_n,oe got %b want 11010", {rd_n, oe_n, rx_tvalid, wr_n, data_oe});
    else n_pass++;
    rxf_n = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({rd_n, oe_n, rx_tvalid, wr_n, data_oe} !== 5'b11010)
        $display("FAIL post_reset_idle[%0d]: got %b want 11010", k, {rd_n, oe_n, rx_tvalid, wr_n, data_oe});
      else n_pass++;
    end
    rxf_n = 1'b0;
    @(posedge clk); #2;
    n_total++;
    if ({rd_n, oe_n} !== 2'b10) $display("FAIL post_reset_grant: rd_n,oe_n got %b want 10", {rd_n, oe_n});
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rx_burst();
    test_rx_full();
    test_tx_burst();
    test_alternate();
    test_reset_mid_rd();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ftdi_sync_arb.md
FTDI_SYNC_ARB -- requirements
Module: ftdi_sync_arb

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of the FTDI bus and both streams (8, 16 or 32).
REQ-002 SHALL have parameter RX_DEPTH, default 4, meaning RX buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter BURST_MAX, default 64, meaning max transfers per bus grant (>=1).
REQ-004 SHALL have parameter RX_PRIORITY, default 1, meaning 1 = RX always wins arbitration, 0 = alternate.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with these ports:
  clk  in  1  FTDI clkout; all logic on rising edge
  rst  in  1  async active-high reset
  data_i  in  DW  FTDI bus input
  data_o  out  DW  FTDI bus drive value
  data_oe  out  1  bus drive enable (top level builds the tristate)
  rxf_n  in  1  FTDI has RX data, active low
  txe_n  in  1  FTDI can accept TX data, active low
  rd_n  out  1  read strobe, active low
  oe_n  out  1  FTDI output enable, active low
  wr_n  out  1  write strobe, active low
  tx_tdata  in  DW  host-to-FTDI stream data
  tx_tvalid  in  1  TX valid
  tx_tready  out  1  TX ready
  rx_tdata  out  DW  FTDI-to-host stream data
  rx_tvalid  out  1  RX valid
  rx_tready  in  1  RX ready

Function
REQ-006 SHALL implement FSM states IDLE, RD_TURN, RD, RD_END, WR; state register only.
REQ-007 SHALL define rx_req = !rxf_n && RX buffer not full; tx_req = !txe_n && tx_tvalid.
REQ-008 IDLE: rx_req only -> RD_TURN; tx_req only -> WR; both -> RD_TURN if RX_PRIORITY=1, else the direction not served by the last grant; neither -> IDLE.
REQ-009 RD_TURN: oe_n=0, rd_n=1, exactly one cycle, -> RD.
REQ-010 RD: oe_n=0; rd_n = !( !rxf_n && buffer not full ), combinational.
REQ-011 A byte/word SHALL be captured into the RX buffer on every edge where state=RD, rd_n=0 and rxf_n=0.
REQ-012 RD -> RD_END when rxf_n=1, buffer full, or burst count reaches BURST_MAX after the current capture.
REQ-013 RD_END: oe_n=1, rd_n=1, exactly one cycle, -> IDLE (bus turnaround).
REQ-014 WR: data_oe=1, data_o=tx_tdata; wr_n = tx_tready = !(!txe_n && tx_tvalid) inverted, i.e. tx_tready=1 and wr_n=0 iff !txe_n && tx_tvalid.
REQ-015 WR -> IDLE when txe_n=1, tx_tvalid=0, or burst count reaches BURST_MAX after the current transfer; data_oe=0 from IDLE onward.
REQ-016 Outside WR: data_oe=0, wr_n=1, tx_tready=0; outside RD_TURN/RD: oe_n=1; outside RD: rd_n=1.
REQ-017 Burst counter SHALL clear on grant entry, increment per transfer, width clog2(BURST_MAX+1), never exceed BURST_MAX.
REQ-018 RX buffer: FIFO, rx_tvalid = not empty, rx_tdata = head, pop on rx_tvalid && rx_tready; pointers wrap modulo RX_DEPTH.
REQ-019 Captured data SHALL appear on rx_tdata one cycle after the capture edge when buffer was empty.
REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged; push when full SHALL never occur (REQ-010).
REQ-021 data_oe and oe_n SHALL never both be active in the same cycle.

Reset
REQ-022 rst=1 SHALL asynchronously force: state IDLE, rd_n=1, oe_n=1, wr_n=1, data_oe=0, tx_tready=0, rx_tvalid=0, buffer empty, burst count 0, last-served = TX.
REQ-023 Reset mid-burst SHALL discard buffered RX data; first grant after release follows REQ-008.

Verification
REQ-024 rxf_n=0 for 3 words 0xA1,0xA2,0xA3, rx_tready=1 -> RD_TURN 1 cycle, rd_n low 3 cycles, rx_tdata sequence A1,A2,A3, RD_END then IDLE.
REQ-025 rxf_n held 0, rx_tready=0, RX_DEPTH=4 -> exactly 4 captures, rd_n rises, RD_END; rx_tready=1 resumes reads with no loss or duplication.
REQ-026 txe_n=0, tx_tvalid=1 continuous counter, BURST_MAX=64 -> wr_n low 64 cycles, data 0..63, IDLE, next grant continues at 64.
REQ-027 rxf_n=0 and tx_req both, RX_PRIORITY=0, BURST_MAX=4 -> grants alternate RX,TX,RX of 4 transfers each; RX_PRIORITY=1 -> TX starved while rxf_n=0.
REQ-028 rst asserted in RD after 2 captures -> oe_n, rd_n high same cycle, rx_tvalid=0; after release bus idle until rxf_n/txe_n request.
REQ-029 Every scenario -> checker confirms REQ-021 (no data_oe with oe_n=0) on all cycles.
